// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data RAM between the CPU dmem port and one peripheral master
module dmem_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_q,
   output logic              cpu_valid,
   input  logic              per_req,
   input  logic              per_wren,
   input  logic              per_lock,
   input  logic [ADDR_W-1:0] per_addr,
   input  logic [DATA_W-1:0] per_data,
   output logic              per_gnt,
   output logic [DATA_W-1:0] per_q,
   output logic              per_valid,
   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut
);
   typedef enum logic {ARB, BURST} state_t;
   typedef enum logic [1:0] {NONE, CPU, PER} own_t;
   state_t state, state_nx;
   own_t rd_own, own_nx;
   logic [3:0] wait_cnt, wait_nx, burst_cnt, burst_nx, burst_inc;
   logic cooldown, cool_nx, in_burst, force_per, lock_entry, burst_done;
   logic [DATA_W-1:0] cpu_hold, per_hold;
   always_comb begin
      in_burst   = state == BURST && per_req && per_lock;
      force_per  = wait_cnt == 4'(MAX_WAIT) && !cooldown;
      per_gnt    = !reset && per_req && (in_burst || !cpu_req || force_per);
      cpu_gnt    = !reset && cpu_req && !per_gnt;
      ram_wEn    = cpu_gnt ? cpu_wren : per_gnt && per_wren;
      ram_addr   = cpu_gnt ? cpu_addr : per_gnt ? per_addr : '0;
      ram_dataIn = cpu_gnt ? cpu_data : per_gnt ? per_data : '0;
      cpu_valid  = !reset && rd_own == CPU;
      per_valid  = !reset && rd_own == PER;
      cpu_q      = reset ? '0 : cpu_valid ? ram_dataOut : cpu_hold;
      per_q      = reset ? '0 : per_valid ? ram_dataOut : per_hold;
      wait_nx    = per_req && !per_gnt ? (wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
      own_nx     = cpu_gnt && !cpu_wren ? CPU : per_gnt && !per_wren ? PER : NONE;
      burst_inc  = burst_cnt + 4'd1;
      // a one-grant burst limit ends the burst on the very grant that would open it
      lock_entry = !in_burst && per_gnt && per_lock && !cooldown;
      burst_done = in_burst ? burst_inc == 4'(BURST_MAX) : lock_entry && BURST_MAX == 1;
      burst_nx   = in_burst ? burst_inc : lock_entry ? 4'd1 : burst_cnt;
      state_nx   = (in_burst || lock_entry) && !burst_done ? BURST : ARB;
      cool_nx    = burst_done;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ARB;
         rd_own    <= NONE;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         cooldown  <= 1'b0;
         cpu_hold  <= '0;
         per_hold  <= '0;
      end else begin
         state     <= state_nx;
         rd_own    <= own_nx;
         wait_cnt  <= wait_nx;
         burst_cnt <= burst_nx;
         cooldown  <= cool_nx;
         cpu_hold  <= cpu_valid ? ram_dataOut : cpu_hold;
         per_hold  <= per_valid ? ram_dataOut : per_hold;
      end
   end
endmodule
